// File: rtl/ws281x_pkg.sv
// Shared types and helpers for the WS281x stream transmitter.
package ws281x_pkg;

  localparam int PIX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PIX,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  typedef enum logic [1:0] {
    ORD_GRB = 2'd0,
    ORD_RGB = 2'd1,
    ORD_BRG = 2'd2,
    ORD_RBG = 2'd3
  } order_e;

  // Puts the three colour bytes of {W,R,G,B} into wire order, first byte
  // in the top bits, and appends W as the last byte.
  function automatic logic [PIX_W-1:0] reorder(input order_e ord,
                                               input logic [PIX_W-1:0] pix);
    logic [7:0] w, r, g, b;
    w = pix[31:24];
    r = pix[23:16];
    g = pix[15:8];
    b = pix[7:0];
    case (ord)
      ORD_GRB: return {g, r, b, w};
      ORD_RGB: return {r, g, b, w};
      ORD_BRG: return {b, r, g, w};
      default: return {r, b, g, w};
    endcase
  endfunction

endpackage

// File: rtl/ws281x_stream_tx_if.sv
// Frame control, pixel stream and status signals of the transmitter.
interface ws281x_stream_tx_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic [CNT_W-1:0] leds;
  logic [1:0]       order;
  logic             pix_valid;
  logic             pix_ready;
  logic [31:0]      pix_data;
  logic             busy;
  logic             done;
  logic             underrun;

  // The frame-buffer reader side.
  modport master (
    output start, leds, order, pix_valid, pix_data,
    input  pix_ready, busy, done, underrun
  );

  // The transmitter side.
  modport slave (
    input  start, leds, order, pix_valid, pix_data,
    output pix_ready, busy, done, underrun
  );
endinterface

// File: rtl/ws281x_bit_gen.sv
// Bit timer and shift register: turns one BPP-bit word into WS281x pulses,
// MSB first. tx_out is registered and lines up with the bit counter, so a
// load in cycle n gives the first high in cycle n+1.
module ws281x_bit_gen
  import ws281x_pkg::*;
#(
  parameter int T_BIT = 25,
  parameter int T0H   = 7,
  parameter int T1H   = 14,
  parameter int BPP   = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [BPP-1:0] word,
  output logic           tx_out,
  output logic           high_last,
  output logic           bit_last,
  output logic           pixel_last
);

  localparam int CW = $clog2(T_BIT);
  localparam int IW = $clog2(BPP);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [IW-1:0] IDX_LAST = IW'(BPP - 1);

  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [BPP-1:0] shift, shift_nxt;
  logic           active, active_nxt;
  logic [CW-1:0]  high_len, high_len_nxt;
  logic           tx_nxt;

  // Next bit-timer/shift state and the line level that goes with it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default in always_comb infers a latch.
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift;
    active_nxt = active;

    high_len   = shift[BPP-1] ? T1H_C : T0H_C;
    bit_last   = active && (cnt == CNT_LAST);
    pixel_last = bit_last && (idx == IDX_LAST);
    high_last  = active && (cnt == high_len - CW'(1));

    if (load) begin
      cnt_nxt    = '0;
      idx_nxt    = '0;
      shift_nxt  = word;
      active_nxt = 1'b1;
    end else if (active) begin
      if (bit_last) begin
        cnt_nxt   = '0;
        shift_nxt = {shift[BPP-2:0], 1'b0};
        if (pixel_last) active_nxt = 1'b0;
        else            idx_nxt    = idx + IW'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

    high_len_nxt = shift_nxt[BPP-1] ? T1H_C : T0H_C;
    tx_nxt       = active_nxt && (cnt_nxt < high_len_nxt);
  end

  // Timer, shift register and registered line output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      active <= 1'b0;
      tx_out <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      shift  <= shift_nxt;
      active <= active_nxt;
      tx_out <= tx_nxt;
    end
  end

endmodule

// File: rtl/ws281x_stream_tx.sv
// WS281x stream transmitter: frame FSM, one-entry pixel holding register,
// pixel counts and status around the bit generator.
module ws281x_stream_tx
  import ws281x_pkg::*;
#(
  parameter int T_BIT   = 25,
  parameter int T0H     = 7,
  parameter int T1H     = 14,
  parameter int T_RESET = 1000,
  parameter int BPP     = 24,
  parameter int CNT_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  ws281x_stream_tx_if.slave   bus,
  output logic                tx_out
);

  localparam int LW = $clog2(T_RESET + 1);
  localparam logic [LW-1:0] LATCH_END = LW'(T_RESET);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] leds_q;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] remaining;
  order_e           order_q;
  logic [BPP-1:0]   hold_q;
  logic [BPP-1:0]   hold_d;
  logic             hold_full;
  logic [LW-1:0]    latch_cnt;
  logic             underrun_q;

  logic busy, take, start_ok, load, set_underrun;
  logic high_last, bit_last, pixel_last;

  assign busy     = (state != ST_IDLE);
  assign start_ok = bus.start && (state == ST_IDLE);
  assign take     = bus.pix_valid && bus.pix_ready;
  assign hold_d   = BPP'(reorder(order_q, bus.pix_data) >> (PIX_W - BPP));

  assign bus.pix_ready = busy && !hold_full && (accepted < leds_q);
  assign bus.busy      = busy;
  assign bus.done      = (state == ST_LATCH) && (latch_cnt == LATCH_END);
  assign bus.underrun  = underrun_q;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, shift-register load and underrun detection.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    set_underrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = (bus.leds == '0) ? ST_LATCH : ST_WAIT_PIX;
      end
      ST_WAIT_PIX: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (high_last) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (pixel_last) begin
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_LATCH;
          end else if (hold_full) begin
            load      = 1'b1;
            state_nxt = ST_HIGH;
          end else begin
            set_underrun = 1'b1;
            state_nxt    = ST_WAIT_PIX;
          end
        end else if (bit_last) begin
          state_nxt = ST_HIGH;
        end
      end
      ST_LATCH: begin
        if (latch_cnt == LATCH_END) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame parameters, pixel counts, holding flag, latch timer and underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q     <= '0;
      order_q    <= ORD_GRB;
      accepted   <= '0;
      remaining  <= '0;
      hold_full  <= 1'b0;
      latch_cnt  <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (start_ok) begin
        leds_q     <= bus.leds;
        order_q    <= order_e'(bus.order);
        accepted   <= '0;
        remaining  <= bus.leds;
        underrun_q <= 1'b0;
      end else if (set_underrun) begin
        underrun_q <= 1'b1;
      end

      if (take) begin
        hold_full <= 1'b1;
        accepted  <= accepted + CNT_W'(1);
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if ((state == ST_LOW) && pixel_last) remaining <= remaining - CNT_W'(1);

      if ((state == ST_LATCH) && (latch_cnt != LATCH_END)) latch_cnt <= latch_cnt + LW'(1);
      else                                                 latch_cnt <= '0;
    end
  end

  // Pixel data capture in wire order.
  always_ff @(posedge clk) begin
    // NOTE: the data register has no reset; it is only read after hold_full
    // marks it valid, and hold_full itself is reset.
    if (take) hold_q <= hold_d;
  end

  ws281x_bit_gen #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H),
    .BPP   (BPP)
  ) u_bit_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .word       (hold_q),
    .tx_out     (tx_out),
    .high_last  (high_last),
    .bit_last   (bit_last),
    .pixel_last (pixel_last)
  );

endmodule

// File: tb/tb_ws281x_stream_tx.sv
// Directed bench for ws281x_stream_tx: a 24-bit and a 32-bit instance,
// decoding tx_out bit by bit and checking frame status.
module tb_ws281x_stream_tx;

  localparam int T_BIT   = 25;
  localparam int T0H     = 7;
  localparam int T1H     = 14;
  localparam int T_RESET = 1000;
  localparam int CNT_W   = 10;

  logic clk = 1'b0;
  logic rst;
  logic tx24, tx32;

  int n_checks = 0;
  int n_fail   = 0;

  // Status event counters sampled mid-cycle on the 24-bit instance.
  int busy_cyc = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  ws281x_stream_tx_if #(.CNT_W(CNT_W)) bus24 ();
  ws281x_stream_tx_if #(.CNT_W(CNT_W)) bus32 ();

  ws281x_stream_tx #(
    .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET), .BPP(24), .CNT_W(CNT_W)
  ) u_dut24 (
    .clk(clk), .rst(rst), .bus(bus24), .tx_out(tx24)
  );

  ws281x_stream_tx #(
    .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET), .BPP(32), .CNT_W(CNT_W)
  ) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .tx_out(tx32)
  );

  always @(negedge clk) begin
    if (bus24.busy === 1'b1) busy_cyc++;
    if (bus24.done === 1'b1) done_cnt++;
    if (bus24.pix_valid === 1'b1 && bus24.pix_ready === 1'b1) hs_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx32 : tx24;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bus32.done : bus24.done;
  endfunction

  // Cycles from now until tx_out rises (limit when it never does).
  task automatic wait_tx_high(input bit sel, input int limit, output int waited);
    waited = 0;
    while (tx_of(sel) !== 1'b1 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Decodes nbits contiguous bits starting at the current cycle; a bit must
  // be T0H or T1H leading highs followed by lows, T_BIT cycles in total.
  task automatic read_bits(input bit sel, input int nbits,
                           output logic [31:0] word, output int bad);
    word = '0;
    bad  = 0;
    for (int b = 0; b < nbits; b++) begin
      int ones;
      bit shape_ok;
      ones     = 0;
      shape_ok = 1'b1;
      for (int c = 0; c < T_BIT; c++) begin
        if (tx_of(sel) === 1'b1) begin
          if (ones != c) shape_ok = 1'b0;
          ones++;
        end else if (tx_of(sel) !== 1'b0) begin
          shape_ok = 1'b0;
        end
        @(negedge clk);
      end
      if (!shape_ok || (ones != T0H && ones != T1H)) bad++;
      word = {word[30:0], (ones == T1H)};
    end
  endtask

  // Cycles from now until done, counting any tx_out highs on the way.
  task automatic wait_done(input bit sel, input int limit, output int n, output int highs);
    n     = 0;
    highs = 0;
    while (done_of(sel) !== 1'b1 && n < limit) begin
      if (tx_of(sel) !== 1'b0) highs++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle_inputs();
    bus24.start = 1'b0; bus24.leds = '0; bus24.order = 2'd0;
    bus24.pix_valid = 1'b0; bus24.pix_data = '0;
    bus32.start = 1'b0; bus32.leds = '0; bus32.order = 2'd0;
    bus32.pix_valid = 1'b0; bus32.pix_data = '0;
  endtask

  initial begin
    int w, n, highs, bad, k;
    int busy0, done0, hs0;
    logic [31:0] word;

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    check("rst_tx24",      32'(tx24), 0);
    check("rst_busy24",    32'(bus24.busy), 0);
    check("rst_done24",    32'(bus24.done), 0);
    check("rst_underrun",  32'(bus24.underrun), 0);
    check("rst_ready24",   32'(bus24.pix_ready), 0);
    check("rst_tx32",      32'(tx32), 0);
    check("rst_busy32",    32'(bus32.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- Single pixel, GRB, R=FF -> wire 0x00FF00 ----
    busy0 = busy_cyc;
    done0 = done_cnt;
    bus24.start = 1'b1; bus24.leds = 10'd1; bus24.order = 2'd0;
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h00FF_0000;
    @(negedge clk);
    bus24.start = 1'b0;
    check("p1_busy_after_start", 32'(bus24.busy), 1);
    check("p1_ready_after_start", 32'(bus24.pix_ready), 1);
    @(negedge clk);
    bus24.pix_valid = 1'b0;
    check("p1_ready_when_full", 32'(bus24.pix_ready), 0);
    check("p1_tx_1_after_hs", 32'(tx24), 0);
    @(negedge clk);
    check("p1_tx_2_after_hs", 32'(tx24), 1);
    read_bits(1'b0, 24, word, bad);
    check("p1_word", word, 32'h0000_FF00);
    check("p1_bit_timing", bad, 0);
    wait_done(1'b0, 1100, n, highs);
    check("p1_latch_len", n, T_RESET);
    check("p1_latch_high", highs, 0);
    // A start in the done cycle is ignored.
    bus24.start = 1'b1; bus24.leds = 10'd1;
    @(negedge clk);
    bus24.start = 1'b0;
    check("p1_start_on_done_ignored", 32'(bus24.busy), 0);
    // 2 intake cycles + 600 bit cycles + 1000 latch cycles + 1 done cycle.
    check("p1_busy_cycles", busy_cyc - busy0, 1603);
    check("p1_done_pulses", done_cnt - done0, 1);
    check("p1_underrun", 32'(bus24.underrun), 0);
    @(negedge clk);

    // ---- Back-to-back, 3 pixels, RGB, start repeated while busy ----
    hs0 = hs_cnt;
    bus24.start = 1'b1; bus24.leds = 10'd3; bus24.order = 2'd1;
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h00A5_3C0F;
    @(negedge clk);
    bus24.leds = 10'd0; bus24.order = 2'd0;   // start still high, now busy
    @(negedge clk);
    bus24.start = 1'b0;
    wait_tx_high(1'b0, 10, w);
    check("b2b_first_high", w, 1);
    for (int p = 0; p < 3; p++) begin
      read_bits(1'b0, 24, word, bad);
      check($sformatf("b2b_word%0d", p), word, 32'h00A5_3C0F);
      check($sformatf("b2b_timing%0d", p), bad, 0);
    end
    check("b2b_ready_after_3", 32'(bus24.pix_ready), 0);
    check("b2b_handshakes", hs_cnt - hs0, 3);
    check("b2b_underrun", 32'(bus24.underrun), 0);
    bus24.pix_valid = 1'b0;
    wait_done(1'b0, 1100, n, highs);
    check("b2b_latch_len", n, T_RESET);
    @(negedge clk);

    // ---- Underrun: second pixel 100 cycles late ----
    bus24.start = 1'b1; bus24.leds = 10'd2; bus24.order = 2'd0;
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h0012_3456;
    @(negedge clk);
    bus24.start = 1'b0;
    @(negedge clk);
    bus24.pix_valid = 1'b0;
    wait_tx_high(1'b0, 10, w);
    check("ur_first_high", w, 1);
    read_bits(1'b0, 24, word, bad);
    check("ur_word1", word, 32'h0034_1256);
    check("ur_timing1", bad, 0);
    check("ur_flag_set", 32'(bus24.underrun), 1);
    check("ur_busy", 32'(bus24.busy), 1);
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx24 !== 1'b0) highs++;
      @(negedge clk);
    end
    check("ur_line_low", highs, 0);
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h00AB_CDEF;
    @(negedge clk);
    bus24.pix_valid = 1'b0;
    wait_tx_high(1'b0, 10, w);
    check("ur_resume_high", w, 1);
    read_bits(1'b0, 24, word, bad);
    check("ur_word2", word, 32'h00CD_ABEF);
    check("ur_timing2", bad, 0);
    wait_done(1'b0, 1100, n, highs);
    check("ur_latch_len", n, T_RESET);
    check("ur_sticky_at_done", 32'(bus24.underrun), 1);
    @(negedge clk);

    // ---- leds=0: latch only; also clears underrun ----
    bus24.start = 1'b1; bus24.leds = 10'd0;
    @(negedge clk);
    bus24.start = 1'b0;
    check("z_underrun_cleared", 32'(bus24.underrun), 0);
    check("z_busy", 32'(bus24.busy), 1);
    wait_done(1'b0, 1100, n, highs);
    check("z_done_delay", n, T_RESET);
    check("z_line_low", highs, 0);
    @(negedge clk);
    check("z_idle_after_done", 32'(bus24.busy), 0);

    // ---- BPP=32, RGB, {W,R,G,B}=0x80010203 -> wire 0x01020380 ----
    bus32.start = 1'b1; bus32.leds = 10'd1; bus32.order = 2'd1;
    bus32.pix_valid = 1'b1; bus32.pix_data = 32'h8001_0203;
    @(negedge clk);
    bus32.start = 1'b0;
    @(negedge clk);
    bus32.pix_valid = 1'b0;
    wait_tx_high(1'b1, 10, w);
    check("w32_first_high", w, 1);
    read_bits(1'b1, 32, word, bad);
    check("w32_word", word, 32'h0102_0380);
    check("w32_timing", bad, 0);
    wait_done(1'b1, 1100, n, highs);
    check("w32_latch_len", n, T_RESET);
    @(negedge clk);

    // ---- Reset in the middle of a high phase ----
    bus24.start = 1'b1; bus24.leds = 10'd2; bus24.order = 2'd0;
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h0000_FF00;
    @(negedge clk);
    bus24.start = 1'b0;
    @(negedge clk);
    bus24.pix_valid = 1'b0;
    wait_tx_high(1'b0, 10, w);
    check("mr_first_high", w, 1);
    repeat (5) @(negedge clk);
    check("mr_tx_mid_bit", 32'(tx24), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_tx", 32'(tx24), 0);
    check("mr_busy", 32'(bus24.busy), 0);
    check("mr_ready", 32'(bus24.pix_ready), 0);
    check("mr_done", 32'(bus24.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh frame after reset behaves as from power-up.
    done0 = done_cnt;
    bus24.start = 1'b1; bus24.leds = 10'd1; bus24.order = 2'd0;
    bus24.pix_valid = 1'b1; bus24.pix_data = 32'h00FF_0000;
    @(negedge clk);
    bus24.start = 1'b0;
    check("pr_ready", 32'(bus24.pix_ready), 1);
    @(negedge clk);
    bus24.pix_valid = 1'b0;
    wait_tx_high(1'b0, 10, w);
    check("pr_first_high", w, 1);
    read_bits(1'b0, 24, word, bad);
    check("pr_word", word, 32'h0000_FF00);
    check("pr_timing", bad, 0);
    wait_done(1'b0, 1100, n, highs);
    check("pr_latch_len", n, T_RESET);
    k = done_cnt - done0;
    @(negedge clk);
    check("pr_done_pulses", done_cnt - done0, 1);
    check("pr_done_seen_by_done_cycle", k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
